// File: rtl/cpu_mux_pkg.sv
// Shared definitions for the CPU operand selectors: mode encodings and
// default sizing.
package cpu_mux_pkg;

    typedef enum logic {
        MODE_DIRECTED = 1'b0,
        MODE_RR       = 1'b1
    } mode_e;

    localparam int unsigned DEFAULT_WIDTH  = 12;
    localparam int unsigned DEFAULT_NUM_IN = 4;

    // Index width for an n-input selector; never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/operand_mux_rr_if.sv
// Handshake bundle between the operand sources, the selector and the ALU
// B-operand input.
interface operand_mux_rr_if
    import cpu_mux_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned NUM_IN = DEFAULT_NUM_IN
);
    localparam int unsigned SEL_W = sel_w(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [SEL_W-1:0]        sel;
    logic                    mode;
    logic                    stall;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic [SEL_W-1:0]        out_sel;
    logic                    sel_err;

    modport master (
        output in_data, in_valid, sel, mode, stall,
        input  in_ready, out_data, out_valid, out_sel, sel_err
    );

    modport slave (
        input  in_data, in_valid, sel, mode, stall,
        output in_ready, out_data, out_valid, out_sel, sel_err
    );

endinterface

// File: rtl/operand_mux_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping
// modulo NUM_IN (not modulo 2^SEL_W).
module rr_arbiter
    import cpu_mux_pkg::*;
#(
    parameter int unsigned NUM_IN = DEFAULT_NUM_IN
) (
    input  logic [NUM_IN-1:0]         req,
    input  logic [sel_w(NUM_IN)-1:0]  ptr,
    input  logic                      en,
    output logic [NUM_IN-1:0]         gnt,
    output logic [sel_w(NUM_IN)-1:0]  gnt_idx
);
    localparam int unsigned SEL_W = sel_w(NUM_IN);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned off = 0; off < NUM_IN; off++) begin
            // ptr < NUM_IN always, so a single conditional subtract wraps it
            idx = 32'(ptr) + 1 + off;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (en && !found && req[SEL_W'(idx)]) begin
                found                = 1'b1;
                gnt[SEL_W'(idx)]     = 1'b1;
                gnt_idx              = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/operand_mux_rr.sv
// Registered N:1 operand selector feeding the ALU B operand, with directed
// and round-robin selection, per-input handshake and output stall.
module operand_mux_rr
    import cpu_mux_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned NUM_IN = DEFAULT_NUM_IN
) (
    input logic             clk,
    input logic             rst_n,
    operand_mux_rr_if.slave bus
);
    localparam int unsigned      SEL_W     = sel_w(NUM_IN);
    localparam logic [SEL_W-1:0] PTR_RESET = SEL_W'(NUM_IN - 1);

    mode_e             mode;
    logic              run;
    logic              rr_en;
    logic              sel_in_range;
    logic              has_gnt;
    logic [NUM_IN-1:0] dir_gnt;
    logic [NUM_IN-1:0] rr_gnt;
    logic [NUM_IN-1:0] gnt;
    logic [SEL_W-1:0]  rr_idx;
    logic [SEL_W-1:0]  gnt_idx;
    logic [WIDTH-1:0]  gnt_data;

    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
    logic              out_valid_q, out_valid_d;
    logic              sel_err_q,   sel_err_d;
    logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

    assign mode         = mode_e'(bus.mode);
    assign run          = rst_n & ~bus.stall;
    assign rr_en        = run & (mode == MODE_RR);
    assign sel_in_range = (32'(bus.sel) < NUM_IN);

    always_comb begin
        dir_gnt = '0;
        if (run && mode == MODE_DIRECTED && sel_in_range && bus.in_valid[bus.sel]) begin
            dir_gnt[bus.sel] = 1'b1;
        end
    end

    rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_rr_arbiter (
        .req     (bus.in_valid),
        .ptr     (rr_ptr_q),
        .en      (rr_en),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    always_comb begin
        gnt     = (mode == MODE_RR) ? rr_gnt : dir_gnt;
        gnt_idx = (mode == MODE_RR) ? rr_idx : bus.sel;
        has_gnt = |gnt;
    end

    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (gnt[i]) begin
                gnt_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        sel_err_d   = (mode == MODE_DIRECTED) && !sel_in_range && !bus.stall;
        if (!bus.stall) begin
            out_valid_d = has_gnt;
            if (has_gnt) begin
                out_data_d = gnt_data;
                out_sel_d  = gnt_idx;
                if (mode == MODE_RR) begin
                    rr_ptr_d = gnt_idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            rr_ptr_q    <= PTR_RESET;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = gnt;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: doc/operand_mux_rr.md
Name: operand_mux_rr

Overview:
- Parametrised successor to the registered 2:1 operand selector in the CPU datapath.
- N-input, WIDTH-bit registered multiplexer with per-input valid/ready handshake and an output stall.
- Two selection modes: directed (the controller drives the select index) and round-robin (automatic fair choice among valid inputs).
- Sits between the register-file/immediate sources and the ALU B-operand input.

Parameters:
- WIDTH, 12, data width of each input and the output.
- NUM_IN, 4, number of inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN), select index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  NUM_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  input i presents data this cycle.
- in_ready  out  NUM_IN  one-hot; input i is accepted this cycle. Combinational.
- sel  in  SEL_W  directed-mode select index.
- mode  in  1  0 = directed, 1 = round-robin.
- stall  in  1  downstream cannot take a new result; output holds.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  out_data is a new result this cycle.
- out_sel  out  SEL_W  index of the input captured into out_data.
- sel_err  out  1  one-cycle pulse: directed sel >= NUM_IN.

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - out_data, out_sel, out_valid and sel_err go to 0.
  - rr_ptr goes to NUM_IN-1, so the first round-robin search starts at input 0.
  - in_ready is 0 while rst_n=0.
  - Reset mid-transfer discards any in-flight result; nothing is replayed.
- Grant (combinational, only when stall=0 and rst_n=1):
  - Directed: grant = sel if sel < NUM_IN and in_valid[sel]=1; otherwise no grant.
  - Round-robin: grant = first i with in_valid[i]=1, searching (rr_ptr+1) mod NUM_IN upward with wrap-around; no grant if in_valid=0.
  - in_ready = one-hot(grant); all zero when there is no grant.
- Capture, latency 1: on the posedge where a grant exists, out_data <= in_data[grant], out_sel <= grant, out_valid <= 1.
- No grant and stall=0: out_valid <= 0; out_data and out_sel hold their last values.
- stall=1: out_data, out_sel and out_valid all hold; in_ready=0; rr_ptr holds.
- rr_ptr updates to grant only on a round-robin-mode grant. Directed grants leave rr_ptr unchanged.
- Mode switch takes effect on the same cycle as the change; no flush is required.
- sel_err:
  - Registered: sel_err <= (mode=0 and sel >= NUM_IN and stall=0).
  - Out-of-range sel never grants and never corrupts the output.
  - Cannot fire when NUM_IN is a power of two.
- Simultaneous in_valid on all inputs in round-robin mode: grants rotate 0,1,..,NUM_IN-1,0.
- No arithmetic. All indices are unsigned; the wrap is modulo NUM_IN, not modulo 2^SEL_W.

Decomposition:
- Shared package cpu_mux_pkg:
  - mode encodings MODE_DIRECTED=1'b0 and MODE_RR=1'b1.
  - default WIDTH 12.
- One natural sub-module: rr_arbiter.
  - Parameter NUM_IN.
  - Inputs req, ptr and en; outputs a one-hot gnt and a gnt_idx.
  - Instantiated once for round-robin mode. Directed-mode decode stays in the top level.

Test Plan (WIDTH=12, NUM_IN=4 unless noted):
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0. Release -> first round-robin grant is input 0.
- Directed: mode=0, sel=2, in_data[2]=12'hA5C, in_valid=4'b0100 -> in_ready=4'b0100; next cycle out_data=12'hA5C, out_sel=2, out_valid=1.
- Directed miss: sel=1 with in_valid=4'b0100 -> in_ready=0; next cycle out_valid=0, out_data still 12'hA5C.
- Round-robin fairness: mode=1, in_valid=4'b1111 held for 6 cycles, stall=0 -> out_sel sequence 0,1,2,3,0,1. Then in_valid=4'b1010 -> grants 3,1,3.
- Stall: assert stall for 3 cycles while out_valid=1, out_data=12'h123 -> outputs frozen, in_ready=0, rr_ptr frozen. Deassert -> the round-robin order resumes where it left off.
- Out-of-range (NUM_IN=3, SEL_W=2): mode=0, sel=3 -> sel_err=1 for one cycle, in_ready=0, out_valid=0. Repeat with stall=1 -> sel_err=0.
